// File: rtl/aes128_round_key_gen.sv
// Iterative AES-128 key schedule: load a cipher key, then emit one round key per clock on w0..w3.
// Optional KEYEXP_RND_IDX_EN adds the rnd output carrying the index of the round key on w0..w3.
module aes128_round_key_gen (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  output logic [31:0]  w0,
  output logic [31:0]  w1,
  output logic [31:0]  w2,
  output logic [31:0]  w3
`ifdef KEYEXP_RND_IDX_EN
  ,
  output logic [3:0]   rnd
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(10);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant for schedule step idx; zero once the ten rounds are used up.
  function automatic logic [7:0] rcon_byte(input logic [CNT_W-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [WORD_W-1:0] r_w0, r_w1, r_w2, r_w3;
  logic [WORD_W-1:0] r_rcon;
  logic [CNT_W-1:0]  r_cnt;

  logic [WORD_W-1:0] w_rot;
  logic [WORD_W-1:0] w_sub;
  logic [WORD_W-1:0] w_t;
  logic [WORD_W-1:0] w_n0, w_n1, w_n2, w_n3;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // RotWord feeds four parallel S-box substitutors.
  assign w_rot = {r_w3[23:0], r_w3[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_sub[8*g +: 8] = SBOX[w_rot[8*g +: 8]];
  end

  assign w_t  = w_sub ^ r_rcon;
  assign w_n0 = r_w0 ^ w_t;
  assign w_n1 = w_n0 ^ r_w1;
  assign w_n2 = w_n1 ^ r_w2;
  assign w_n3 = w_n2 ^ r_w3;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_cnt_nxt = (r_cnt == LAST_RND) ? r_cnt : w_cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_w0   <= '0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_w3   <= '0;
      r_rcon <= '0;
      r_cnt  <= '0;
    end else if (ld) begin
      r_w0   <= key[127:96];
      r_w1   <= key[95:64];
      r_w2   <= key[63:32];
      r_w3   <= key[31:0];
      r_rcon <= {rcon_byte(CNT_W'(0)), 24'h000000};
      r_cnt  <= '0;
    end else begin
      r_w0   <= w_n0;
      r_w1   <= w_n1;
      r_w2   <= w_n2;
      r_w3   <= w_n3;
      r_rcon <= {rcon_byte(w_cnt_inc), 24'h000000};
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign w0 = r_w0;
  assign w1 = r_w1;
  assign w2 = r_w2;
  assign w3 = r_w3;

`ifdef KEYEXP_RND_IDX_EN
  assign rnd = r_cnt;
`endif

endmodule

// File: tb/tb_aes128_round_key_gen.sv
// Scoreboard bench for aes128_round_key_gen using FIPS-197 and all-zero-key directed vectors.
module tb_aes128_round_key_gen;

  localparam logic [127:0] K_FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;
  localparam logic [127:0] F_R1   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] F_R2   = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
  localparam logic [127:0] F_R3   = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
  localparam logic [127:0] F_R4   = 128'hef44a541_a8525b7f_b671253b_db0bad00;
  localparam logic [127:0] F_R5   = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
  localparam logic [127:0] F_R10  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
  localparam logic [127:0] R_ADV  = 128'h63636363_63636363_63636363_63636363;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld;
  logic [127:0] key;
  logic [31:0]  w0, w1, w2, w3;
`ifdef KEYEXP_RND_IDX_EN
  logic [3:0]   rnd;
`endif

  aes128_round_key_gen dut (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .key (key),
    .w0  (w0),
    .w1  (w1),
    .w2  (w2),
    .w3  (w3)
`ifdef KEYEXP_RND_IDX_EN
    ,
    .rnd (rnd)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    bit           chk_w;
    logic [127:0] w;
    logic [3:0]   r;
    string        nm;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Monitor: compare the expectation due in the current cycle against the DUT outputs.
  initial begin
    exp_t e;
    logic [127:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        got = {w0, w1, w2, w3};
        if (e.cyc != cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.nm, e.cyc, cyc);
        end else begin
          if (e.chk_w) begin
            n_checks++;
            if (got !== e.w) begin
              n_errors++;
              $display("FAIL %s words: got %h expected %h", e.nm, got, e.w);
            end
          end
`ifdef KEYEXP_RND_IDX_EN
          n_checks++;
          if (rnd !== e.r) begin
            n_errors++;
            $display("FAIL %s rnd: got %0d expected %0d", e.nm, rnd, e.r);
          end
`endif
        end
      end
    end
  end

  // Drive one cycle of inputs; optionally queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic l, input logic [127:0] k,
                      input bit chk, input bit chk_w, input logic [127:0] ew,
                      input logic [3:0] er, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    ld  = l;
    key = k;
    if (chk) begin
      e.cyc   = cyc + 1;
      e.chk_w = chk_w;
      e.w     = ew;
      e.r     = er;
      e.nm    = nm;
      q.push_back(e);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, K_ZERO, 1'b0, 1'b0, '0, '0, "");
  endtask

  initial begin
    logic [127:0] rkey;
    int budget;
    rkey = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b0;
    ld  = 1'b1;
    key = rkey;

    // Reset wins over ld
    step(1'b0, 1'b1, rkey, 1'b1, 1'b1, '0, 4'd0, "reset_a");
    step(1'b0, 1'b1, rkey, 1'b1, 1'b1, '0, 4'd0, "reset_b");

    // FIPS-197 vector
    step(1'b1, 1'b1, K_FIPS, 1'b1, 1'b1, K_FIPS, 4'd0, "fips_key");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R1, 4'd1, "fips_r1");
    adv(8);
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R10, 4'd10, "fips_r10");

    // All-zero key plus index saturation past round 10
    step(1'b1, 1'b1, K_ZERO, 1'b1, 1'b1, K_ZERO, 4'd0, "zero_key");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, Z_R1, 4'd1, "zero_r1");
    adv(8);
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, Z_R10, 4'd10, "zero_r10");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b0, '0, 4'd10, "rnd_sat");

    // Reload mid-schedule
    step(1'b1, 1'b1, K_FIPS, 1'b1, 1'b1, K_FIPS, 4'd0, "reld_key");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R1, 4'd1, "reld_r1");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R2, 4'd2, "reld_r2");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R3, 4'd3, "reld_r3");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R4, 4'd4, "reld_r4");
    step(1'b1, 1'b1, K_ZERO, 1'b1, 1'b1, K_ZERO, 4'd0, "reld_zero");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, Z_R1, 4'd1, "reld_z_r1");

    // ld held three cycles
    step(1'b1, 1'b1, K_FIPS, 1'b1, 1'b1, K_FIPS, 4'd0, "hold_1");
    step(1'b1, 1'b1, K_FIPS, 1'b1, 1'b1, K_FIPS, 4'd0, "hold_2");
    step(1'b1, 1'b1, K_FIPS, 1'b1, 1'b1, K_FIPS, 4'd0, "hold_3");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R1, 4'd1, "hold_r1");

    // Reset mid-schedule, free-run from zero, then fresh load
    step(1'b1, 1'b1, K_FIPS, 1'b1, 1'b1, K_FIPS, 4'd0, "mrst_key");
    adv(4);
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R5, 4'd5, "mrst_r5");
    step(1'b0, 1'b0, K_ZERO, 1'b1, 1'b1, '0, 4'd0, "mrst_zero");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, R_ADV, 4'd1, "mrst_adv");
    step(1'b1, 1'b1, K_FIPS, 1'b1, 1'b1, K_FIPS, 4'd0, "mrst_reld");
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R1, 4'd1, "mrst_r1");
    adv(8);
    step(1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, F_R10, 4'd10, "mrst_r10");

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
